// File: rtl/uart_tx_word_unpacker.sv
// Sends each 32-bit FIFO word as four back-to-back UART frames (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined). BYTE_ORDER selects which end of the word goes first.
module uart_tx_word_unpacker #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter              BYTE_ORDER = "LSB_FIRST"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic        tx_en,
  output logic        uart_tx,
  output logic        busy,
  output logic        word_done
);

  localparam int unsigned    BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam bit             MSB_FIRST = (BYTE_ORDER == "MSB_FIRST");

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   word_q, word_d;
  logic          baud_last;
  logic          pop;
  logic [1:0]    byte_sel;
  logic [7:0]    cur_byte;

  assign baud_last = (baud_q == BAUD_LAST);
  assign pop       = (state_q == IDLE) && tx_en && !fifo_empty && !rst;
  // For MSB_FIRST, byte k comes from lane 3-k, which is the bitwise inverse of k.
  assign byte_sel  = MSB_FIRST ? ~byte_q : byte_q;
  assign cur_byte  = word_q[{byte_sel, 3'b000} +: 8];

  assign fifo_rd_en = pop;
  assign busy       = (state_q != IDLE);
  assign word_done  = (state_q == STOP) && baud_last && (byte_q == 2'd3) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    uart_tx = 1'b1;
    // The baud counter restarts on every bit/state change and never passes BAUD_LAST.
    baud_d  = (state_q == IDLE || baud_last) ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: begin
        if (pop) begin
          word_d  = fifo_rd_data;
          byte_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (baud_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        uart_tx = cur_byte[bit_q];
        if (baud_last) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        uart_tx = ^cur_byte;
        if (baud_last) state_d = STOP;
      end
`endif
      STOP: begin
        uart_tx = 1'b1;
        if (baud_last) begin
          if (byte_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_word_unpacker.sv
// Drives an LSB_FIRST and an MSB_FIRST instance from model FIFOs and decodes
// their serial lines against bytes derived directly from the pushed words.
module tb_uart_tx_word_unpacker;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * BD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [31:0] rd_data[2];
  logic        fifo_empty[2];
  logic        rd_en[2];
  logic        utx[2];
  logic        busy[2];
  logic        wdone[2];

  logic [31:0] push_mem[2][64];
  logic [7:0]  exp_b[2][256];
  int          push_wr[2];
  int          push_rd[2];
  int          cyc;

  int          pops[2], done_cnt[2], pop_cyc[2], last_done[2], rx_idx[2], s_cyc[2];
  bit          in_fr[2], have_done[2];
  logic [7:0]  rb[2];

  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  uart_tx_word_unpacker #(.BAUD_DIV(BD), .BYTE_ORDER("LSB_FIRST")) dut_lsb (
    .clk(clk), .rst(rst), .fifo_rd_data(rd_data[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rd_en(rd_en[0]), .tx_en(tx_en), .uart_tx(utx[0]), .busy(busy[0]),
    .word_done(wdone[0])
  );

  uart_tx_word_unpacker #(.BAUD_DIV(BD), .BYTE_ORDER("MSB_FIRST")) dut_msb (
    .clk(clk), .rst(rst), .fifo_rd_data(rd_data[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rd_en(rd_en[1]), .tx_en(tx_en), .uart_tx(utx[1]), .busy(busy[1]),
    .word_done(wdone[1])
  );

  assign fifo_empty[0] = (push_wr[0] == push_rd[0]);
  assign fifo_empty[1] = (push_wr[1] == push_rd[1]);
  assign rd_data[0]    = push_mem[0][push_rd[0] % 64];
  assign rd_data[1]    = push_mem[1][push_rd[1] % 64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++)
      if (rd_en[g] === 1'b1) push_rd[g] <= push_rd[g] + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic string tg(input string name, input int g);
    return $sformatf("%s_%0d", name, g);
  endfunction

  task automatic push_word(input int g, input logic [31:0] w);
    push_mem[g][push_wr[g]] = w;
    for (int k = 0; k < 4; k++)
      exp_b[g][push_wr[g] * 4 + k] = (g == 0) ? w[8 * k +: 8] : w[24 - 8 * k +: 8];
    push_wr[g]++;
  endtask

  task automatic mon(input int g);
    int t, b;
    if (rst) begin
      in_fr[g]  = 1'b0;
      rx_idx[g] = pops[g] * 4;
      return;
    end
    if (rd_en[g] === 1'b1) begin
      check(tg("pop_idle", g), busy[g], 0);
      check(tg("pop_nonempty", g), fifo_empty[g], 0);
      check(tg("pop_txen", g), tx_en, 1);
      pop_cyc[g] = cyc;
      pops[g]++;
    end
    if (wdone[g] === 1'b1) begin
      check(tg("done_latency", g), cyc - pop_cyc[g], 4 * FR);
      check(tg("done_bytes", g), rx_idx[g], pops[g] * 4);
      done_cnt[g]++;
      last_done[g] = cyc;
      have_done[g] = 1'b1;
    end
    if (!in_fr[g] && utx[g] === 1'b0) begin
      in_fr[g] = 1'b1;
      s_cyc[g] = cyc;
      if (rx_idx[g] % 4 == 0) begin
        check(tg("start_latency", g), cyc - pop_cyc[g], 1);
        if (have_done[g]) check(tg("word_gap", g), (cyc - last_done[g]) >= 2, 1);
      end
    end
    if (in_fr[g]) begin
      t = cyc - s_cyc[g];
      if (t % BD == BD / 2) begin
        b = t / BD;
        if (b == 0) check(tg("start_bit", g), utx[g], 0);
        else if (b <= 8) rb[g][b - 1] = utx[g];
        else if (b == NB - 1) begin
          check(tg("stop_bit", g), utx[g], 1);
          check(tg("byte", g), rb[g], exp_b[g][rx_idx[g]]);
          rx_idx[g]++;
        end
`ifdef UART_TX_PARITY_EN
        else check(tg("parity", g), utx[g], ^rb[g]);
`endif
      end
      if (t == FR - 1) in_fr[g] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) mon(g);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int c = 0;
    while ((done_cnt[0] < n || done_cnt[1] < n) && c < budget) begin
      tick();
      c++;
    end
    check("wait_done", (done_cnt[0] >= n && done_cnt[1] >= n), 1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c = 0;
    while ((pops[0] < n || pops[1] < n) && c < budget) begin
      tick();
      c++;
    end
    check("wait_pops", (pops[0] >= n && pops[1] >= n), 1);
  endtask

  initial begin
    logic [31:0] w;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      check(tg("rst_uart_tx", g), utx[g], 1);
      check(tg("rst_busy", g), busy[g], 0);
      check(tg("rst_rd_en", g), rd_en[g], 0);
      check(tg("rst_word_done", g), wdone[g], 0);
    end
    rst   = 1'b0;
    tx_en = 1'b1;

    // Single known word: LSB order on instance 0, MSB order on instance 1.
    push_word(0, 32'h44332211);
    push_word(1, 32'h44332211);
    wait_done(1, 6 * FR);
    check("pops_single", pops[0] + pops[1], 2);

    // Two queued words back to back.
    push_word(0, 32'h000000FF);
    push_word(1, 32'h000000FF);
    w = $urandom;
    push_word(0, w);
    push_word(1, w);
    wait_done(3, 12 * FR);
    check("pops_two", pops[0] + pops[1], 6);

    // tx_en dropped during byte 1: word completes, next pop held off.
    for (int g = 0; g < 2; g++) begin
      push_word(g, $urandom);
      push_word(g, $urandom);
    end
    wait_pops(4, 20);
    repeat (FR + 5) tick();
    tx_en = 1'b0;
    wait_done(4, 6 * FR);
    repeat (4 * FR + 20) tick();
    check("pops_held", pops[0] + pops[1], 8);
    check("busy_held", busy[0] | busy[1], 0);
    tx_en = 1'b1;
    wait_done(5, 6 * FR);

    // Reset during DATA of byte 2 truncates the frame and drops the word.
    push_word(0, $urandom);
    push_word(1, $urandom);
    wait_pops(6, 20);
    repeat (2 * FR + BD + 10) tick();
    check("busy_before_rst", busy[0] & busy[1], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check(tg("abort_uart_tx", g), utx[g], 1);
      check(tg("abort_busy", g), busy[g], 0);
    end
    repeat (4 * FR + 10) tick();
    check("abort_no_done", done_cnt[0] + done_cnt[1], 10);

    // Random words with random tx_en gating and random push spacing.
    for (int i = 0; i < 8; i++) begin
      tx_en = ($urandom_range(3) != 0);
      push_word(0, $urandom);
      push_word(1, $urandom);
      repeat ($urandom_range(200)) tick();
    end
    tx_en = 1'b1;
    wait_done(13, 8 * 6 * FR);
    repeat (10) tick();

    for (int g = 0; g < 2; g++) begin
      check(tg("total_pops", g), pops[g], push_wr[g]);
      check(tg("total_done", g), done_cnt[g], push_wr[g] - 1);
      check(tg("total_bytes", g), rx_idx[g], push_wr[g] * 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
